// File: rtl/gemm_loop_controller.sv
// Loop/address controller for a single-MAC GEMM datapath: walks m, n, k over
// row-major A, B and C and aligns MAC valid/clear and C writes to a 1-cycle SRAM read.
module gemm_loop_controller #(
    parameter int AddrWidth     = 12,
    parameter int SizeAddrWidth = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [SizeAddrWidth-1:0] M_size_i,
    input  logic [SizeAddrWidth-1:0] K_size_i,
    input  logic [SizeAddrWidth-1:0] N_size_i,
    output logic [AddrWidth-1:0]     sram_a_addr_o,
    output logic [AddrWidth-1:0]     sram_b_addr_o,
    output logic [AddrWidth-1:0]     sram_c_addr_o,
    output logic                     sram_c_we_o,
    output logic                     mac_valid_o,
    output logic                     mac_clear_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int ProdW = 2 * SizeAddrWidth + 1;
    localparam int WideW = (ProdW > AddrWidth) ? ProdW : AddrWidth;
    localparam logic [SizeAddrWidth-1:0] One = SizeAddrWidth'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [SizeAddrWidth-1:0] r_m_size, r_k_size, r_n_size;
    logic [SizeAddrWidth-1:0] r_m, r_n, r_k;
    logic                     r_drain_cnt;

    logic                     r_valid_d1, r_clear_d1, r_we_d1, r_we_d2;
    logic [AddrWidth-1:0]     r_c_addr_d1, r_c_addr_d2;

    logic w_accept, w_start_zero, w_issue;
    logic w_k_last, w_n_last, w_m_last, w_tuple_last;
    logic [AddrWidth-1:0] w_a_addr, w_b_addr, w_c_addr;

    assign w_accept     = (r_state == S_IDLE) && start_i;
    assign w_start_zero = (M_size_i == '0) || (K_size_i == '0) || (N_size_i == '0);
    assign w_issue      = (r_state == S_RUN);
    assign w_k_last     = (r_k == r_k_size - One);
    assign w_n_last     = (r_n == r_n_size - One);
    assign w_m_last     = (r_m == r_m_size - One);
    assign w_tuple_last = w_issue && w_k_last && w_n_last && w_m_last;

    // Products are formed at full width and only then truncated, so addresses wrap.
    assign w_a_addr = AddrWidth'(WideW'(r_m) * WideW'(r_k_size) + WideW'(r_k));
    assign w_b_addr = AddrWidth'(WideW'(r_k) * WideW'(r_n_size) + WideW'(r_n));
    assign w_c_addr = AddrWidth'(WideW'(r_m) * WideW'(r_n_size) + WideW'(r_n));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            // A zero-size job spends a single cycle in DRAIN so done lands at t0+2.
            S_IDLE:  if (start_i) w_state_next = w_start_zero ? S_DRAIN : S_RUN;
            S_RUN:   if (w_tuple_last) w_state_next = S_DRAIN;
            S_DRAIN: if (r_drain_cnt) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_m_size    <= '0;
            r_k_size    <= '0;
            r_n_size    <= '0;
            r_m         <= '0;
            r_n         <= '0;
            r_k         <= '0;
            r_drain_cnt <= 1'b0;
        end else if (w_accept) begin
            r_m_size    <= M_size_i;
            r_k_size    <= K_size_i;
            r_n_size    <= N_size_i;
            r_m         <= '0;
            r_n         <= '0;
            r_k         <= '0;
            r_drain_cnt <= w_start_zero;
        end else if (w_issue) begin
            if (w_k_last) begin
                r_k <= '0;
                if (w_n_last) begin
                    r_n <= '0;
                    r_m <= w_m_last ? '0 : r_m + One;
                end else begin
                    r_n <= r_n + One;
                end
            end else begin
                r_k <= r_k + One;
            end
        end else if (r_state == S_DRAIN) begin
            r_drain_cnt <= 1'b1;
        end
    end

    // Valid/clear follow the issue by one cycle (SRAM read); the C write by two (MAC update).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid_d1  <= 1'b0;
            r_clear_d1  <= 1'b0;
            r_we_d1     <= 1'b0;
            r_c_addr_d1 <= '0;
            r_we_d2     <= 1'b0;
            r_c_addr_d2 <= '0;
        end else begin
            r_valid_d1  <= w_issue;
            r_clear_d1  <= w_issue && (r_k == '0);
            r_we_d1     <= w_issue && w_k_last;
            r_c_addr_d1 <= (w_issue && w_k_last) ? w_c_addr : '0;
            r_we_d2     <= r_we_d1;
            r_c_addr_d2 <= r_c_addr_d1;
        end
    end

    assign sram_a_addr_o = w_issue ? w_a_addr : '0;
    assign sram_b_addr_o = w_issue ? w_b_addr : '0;
    assign sram_c_addr_o = r_c_addr_d2;
    assign sram_c_we_o   = r_we_d2;
    assign mac_valid_o   = r_valid_d1;
    assign mac_clear_o   = r_clear_d1;
    assign busy_o        = (r_state != S_IDLE);
    assign done_o        = (r_state == S_DONE);

endmodule

// File: tb/tb_gemm_loop_controller.sv
// Scoreboard bench: a small SRAM+MAC environment around the controller, with
// expected issues, C writes and done pulses derived from the GEMM definition.
module tb_gemm_loop_controller;

    logic        clk_i = 1'b0;
    logic        rst_i, start_i;
    logic [7:0]  M_size_i, K_size_i, N_size_i;
    logic [11:0] sram_a_addr_o, sram_b_addr_o, sram_c_addr_o;
    logic        sram_c_we_o, mac_valid_o, mac_clear_o, busy_o, done_o;

    gemm_loop_controller #(.AddrWidth(12), .SizeAddrWidth(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .M_size_i(M_size_i), .K_size_i(K_size_i), .N_size_i(N_size_i),
        .sram_a_addr_o(sram_a_addr_o), .sram_b_addr_o(sram_b_addr_o),
        .sram_c_addr_o(sram_c_addr_o), .sram_c_we_o(sram_c_we_o),
        .mac_valid_o(mac_valid_o), .mac_clear_o(mac_clear_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    endtask

    // Environment: A/B SRAMs with one-cycle registered read and the MAC accumulator.
    int mem_a [4096];
    int mem_b [4096];
    int a_rd = 0, b_rd = 0, acc = 0;
    always @(posedge clk_i) begin
        a_rd <= mem_a[sram_a_addr_o];
        b_rd <= mem_b[sram_b_addr_o];
        if (mac_valid_o) acc <= mac_clear_o ? a_rd * b_rd : acc + a_rd * b_rd;
    end

    typedef struct { int a; int b; int clr; int cyc; } issue_t;
    typedef struct { int addr; int data; int cyc; } cw_t;
    issue_t iq[$];
    cw_t    cq[$];
    int     dq[$];

    // Expected sample cycle of event "t0+j" is base+j, base = cyc when start was driven.
    task automatic expect_job(input int m, input int k, input int n, input int base);
        issue_t ei;
        cw_t    ec;
        int     sum;
        if (m * k * n == 0) begin
            dq.push_back(base + 2);
            return;
        end
        for (int mi = 0; mi < m; mi++)
            for (int ni = 0; ni < n; ni++) begin
                sum = 0;
                for (int ki = 0; ki < k; ki++) begin
                    ei.a   = (mi * k + ki) % 4096;
                    ei.b   = (ki * n + ni) % 4096;
                    ei.clr = (ki == 0) ? 1 : 0;
                    ei.cyc = base + 2 + (mi * n + ni) * k + ki;
                    iq.push_back(ei);
                    sum += mem_a[ei.a] * mem_b[ei.b];
                end
                ec.addr = (mi * n + ni) % 4096;
                ec.data = sum;
                ec.cyc  = base + (mi * n + ni + 1) * k + 2;
                cq.push_back(ec);
            end
        dq.push_back(base + m * k * n + 3);
    endtask

    int prev_a = 0, prev_b = 0;
    always @(negedge clk_i) begin
        issue_t ei;
        cw_t    ec;
        int     dc;
        #1;
        if (rst_i) begin
            prev_a = 0;
            prev_b = 0;
        end else begin
            if (mac_valid_o) begin
                if (iq.size() == 0) check("unexpected_valid", 1, 0);
                else begin
                    ei = iq.pop_front();
                    check("a_addr", prev_a, ei.a);
                    check("b_addr", prev_b, ei.b);
                    check("mac_clear", mac_clear_o, ei.clr);
                    check("valid_cycle", cyc, ei.cyc);
                end
            end
            if (sram_c_we_o) begin
                if (cq.size() == 0) check("unexpected_c_write", 1, 0);
                else begin
                    ec = cq.pop_front();
                    check("c_addr", sram_c_addr_o, ec.addr);
                    check("c_data", acc, ec.data);
                    check("c_cycle", cyc, ec.cyc);
                end
            end
            if (done_o) begin
                if (dq.size() == 0) check("unexpected_done", 1, 0);
                else begin
                    dc = dq.pop_front();
                    check("done_cycle", cyc, dc);
                end
            end
            prev_a = sram_a_addr_o;
            prev_b = sram_b_addr_o;
        end
    end

    task automatic fill_mem();
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = int'($urandom_range(0, 255));
            mem_b[i] = int'($urandom_range(0, 255));
        end
    endtask

    task automatic start_job(input int m, input int k, input int n, output int base);
        M_size_i = 8'(m);
        K_size_i = 8'(k);
        N_size_i = 8'(n);
        start_i  = 1'b1;
        base     = cyc;
        expect_job(m, k, n, base);
        @(negedge clk_i);
        start_i = 1'b0;
        check("busy_after_start", busy_o, 1);
    endtask

    // Sizes are scrambled every cycle to show they are ignored once latched.
    task automatic wait_idle(input int exp_idle_cyc);
        int budget = 40000;
        while (busy_o && budget > 0) begin
            @(negedge clk_i);
            M_size_i = 8'($urandom);
            K_size_i = 8'($urandom);
            N_size_i = 8'($urandom);
            budget--;
        end
        check("idle_reached", budget > 0, 1);
        check("busy_fall_cycle", cyc, exp_idle_cyc);
        @(negedge clk_i);
        check("pending_issues", iq.size(), 0);
        check("pending_c_writes", cq.size(), 0);
        check("pending_done", dq.size(), 0);
    endtask

    task automatic run_job(input int m, input int k, input int n);
        int base;
        fill_mem();
        start_job(m, k, n, base);
        wait_idle(base + ((m * k * n == 0) ? 3 : m * k * n + 4));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a_addr"}, sram_a_addr_o, 0);
        check({tag, "_b_addr"}, sram_b_addr_o, 0);
        check({tag, "_c_addr"}, sram_c_addr_o, 0);
        check({tag, "_c_we"}, sram_c_we_o, 0);
        check({tag, "_valid"}, mac_valid_o, 0);
        check({tag, "_clear"}, mac_clear_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, m, k, n;
        rst_i = 1'b1;
        start_i = 1'b0;
        M_size_i = '0;
        K_size_i = '0;
        N_size_i = '0;
        repeat (3) @(negedge clk_i);
        check_all_zero("reset");
        rst_i = 1'b0;
        @(negedge clk_i);

        run_job(2, 2, 2);
        run_job(3, 1, 2);
        run_job(4, 0, 4);
        run_job(1, 5, 0);

        // Second start pulse in the middle of an 8x8x8 run must be ignored.
        fill_mem();
        start_job(8, 8, 8, base);
        while (cyc != base + 5) @(negedge clk_i);
        M_size_i = 8'd3;
        K_size_i = 8'd3;
        N_size_i = 8'd3;
        start_i  = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        wait_idle(base + 512 + 4);

        // Start held through DONE is taken only in the following IDLE cycle.
        fill_mem();
        start_job(2, 1, 1, base);
        while (cyc != base + 5) @(negedge clk_i);
        check("done_in_chain", done_o, 1);
        M_size_i = 8'd1;
        K_size_i = 8'd2;
        N_size_i = 8'd3;
        start_i  = 1'b1;
        expect_job(1, 2, 3, base + 6);
        @(negedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        wait_idle(base + 6 + 6 + 4);

        // Asynchronous reset mid-run aborts everything.
        fill_mem();
        start_job(4, 4, 4, base);
        while (cyc != base + 20) @(negedge clk_i);
        rst_i = 1'b1;
        iq.delete();
        cq.delete();
        dq.delete();
        #1;
        check_all_zero("abort");
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (30) @(negedge clk_i);
        check("idle_after_abort", busy_o, 0);
        run_job(4, 4, 4);

        // Random shapes plus the largest square case.
        for (int j = 0; j < 3; j++) begin
            do begin
                m = int'($urandom_range(1, 32));
                k = int'($urandom_range(1, 32));
                n = int'($urandom_range(1, 32));
            end while (m * k * n > 8000);
            $display("job M=%0d K=%0d N=%0d", m, k, n);
            run_job(m, k, n);
        end
        run_job(32, 32, 32);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
